// File: rtl/generation_scheduler.sv
// Sequences one Game-of-Life generation at a time: launches the update engine, then
// swaps the double buffer only on a video frame boundary. Optional GEN_COUNT_EN adds gen_count_out.
module generation_scheduler #(
  parameter int SPEED_W = 4,
  parameter int GEN_W   = 16
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               run_in,
  input  logic               step_in,
  input  logic               vsync_in,
  input  logic [SPEED_W-1:0] speed_in,
  input  logic               logic_done_in,
  output logic               logic_start_out,
  output logic               swap_out,
  output logic               busy_out
`ifdef GEN_COUNT_EN
  ,
  output logic [GEN_W-1:0]   gen_count_out
`endif
);

  typedef enum logic [1:0] {IDLE, COMPUTE, WAIT_FRAME, SWAP} state_e;

  localparam logic [SPEED_W-1:0] CntMax = '1;

  state_e             state_q, state_d;
  logic [SPEED_W-1:0] frame_cnt_q, frame_cnt_d;
  logic               step_pend_q, step_pend_d;
  logic               start_q, swap_q, busy_q;
  logic               launch;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q     <= IDLE;
      frame_cnt_q <= '0;
      step_pend_q <= 1'b0;
      start_q     <= 1'b0;
      swap_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      frame_cnt_q <= frame_cnt_d;
      step_pend_q <= step_pend_d;
      start_q     <= launch;
      swap_q      <= (state_d == SWAP);
      busy_q      <= (state_d != IDLE);
    end
  end

  always_comb begin
    state_d = state_q;
    launch  = 1'b0;
    case (state_q)
      IDLE: begin
        if (step_pend_q || (run_in && (frame_cnt_q >= speed_in))) begin
          launch  = 1'b1;
          state_d = COMPUTE;
        end
      end
      COMPUTE:    if (logic_done_in) state_d = vsync_in ? SWAP : WAIT_FRAME;
      WAIT_FRAME: if (vsync_in) state_d = SWAP;
      SWAP:       state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  // The vsync that triggers the swap starts the next frame window, so it is not counted.
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (state_d == SWAP)                         frame_cnt_d = '0;
    else if (vsync_in && (frame_cnt_q != CntMax)) frame_cnt_d = frame_cnt_q + 1'b1;
  end

  // A step arriving in the launch cycle is a fresh request and survives the clear.
  always_comb begin
    step_pend_d = step_pend_q;
    if (launch)              step_pend_d = 1'b0;
    if (step_in && !run_in)  step_pend_d = 1'b1;
  end

  assign logic_start_out = start_q;
  assign swap_out        = swap_q;
  assign busy_out        = busy_q;

`ifdef GEN_COUNT_EN
  logic [GEN_W-1:0] gen_cnt_q;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in)                gen_cnt_q <= '0;
    else if (state_d == SWAP)  gen_cnt_q <= gen_cnt_q + 1'b1;
  end

  assign gen_count_out = gen_cnt_q;
`else
  logic unused_gen_w;
  assign unused_gen_w = (GEN_W > 0);
`endif

endmodule

// File: tb/tb_generation_scheduler.sv
// Scoreboard bench for generation_scheduler: expected swap cycles are queued as vsyncs
// are driven and popped by a monitor when swap_out fires.
module tb_generation_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       run = 1'b0, step = 1'b0, vsync = 1'b0, done = 1'b0;
  logic [3:0] speed = '0;
  logic       start, swap, busy;
`ifdef GEN_COUNT_EN
  logic [15:0] gen_count;
`endif

  generation_scheduler #(.SPEED_W(4), .GEN_W(16)) dut (
    .clk_in(clk), .rst_in(rst), .run_in(run), .step_in(step), .vsync_in(vsync),
    .speed_in(speed), .logic_done_in(done),
    .logic_start_out(start), .swap_out(swap), .busy_out(busy)
`ifdef GEN_COUNT_EN
    , .gen_count_out(gen_count)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, failures = 0;
  int starts = 0, swaps = 0, last_start = -1, last_swap = -1;
  int exp_q[$];

  // environment: engine model and periodic vsync source
  bit auto_eng = 0, auto_vs = 0, eng_pend = 0;
  int eng_delay = 10, done_at = 0;
  int vper = 1000, vs_ctr = 0, vs_idx = 0, swap_every = 1, swap_phase = 0;

  always @(negedge clk) begin : monitor
    int e;
    if (!rst) begin
      if (start) begin starts++; last_start = cyc; end
      if (swap) begin
        swaps++; last_swap = cyc;
        checks++;
        if (exp_q.size() == 0) begin
          failures++; $display("FAIL unexpected_swap at cycle %0d (none expected)", cyc);
        end else begin
          e = exp_q.pop_front();
          if (cyc !== e) begin
            failures++; $display("FAIL swap_timing got cycle %0d expected %0d", cyc, e);
          end
        end
        checks++;
        if (swaps > starts) begin
          failures++; $display("FAIL swap_without_start swaps=%0d starts=%0d", swaps, starts);
        end
      end
    end
  end

  task automatic tick(input logic vs = 1'b0, input logic dn = 1'b0, input logic st = 1'b0);
    @(posedge clk); #1;
    if (start) begin eng_pend = 1; done_at = cyc + eng_delay; end
    vsync = vs; done = dn; step = st;
    if (auto_eng && eng_pend && cyc == done_at) begin done = 1'b1; eng_pend = 0; end
    if (auto_vs) begin
      if (vs_ctr == 0) begin
        vsync = 1'b1; vs_ctr = vper - 1;
        if (vs_idx % swap_every == swap_phase) exp_q.push_back(cyc + 1);
        vs_idx++;
      end else vs_ctr--;
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; run = 0; step = 0; vsync = 0; done = 0; speed = '0;
    auto_eng = 0; auto_vs = 0; eng_pend = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    starts = 0; swaps = 0; last_start = -1; last_swap = -1; vs_idx = 0;
    exp_q.delete();
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({start, swap, busy} !== 3'b000) begin
      failures++; $display("FAIL reset_outputs got %b expected 000", {start, swap, busy});
    end
`ifdef GEN_COUNT_EN
    checks++;
    if (gen_count !== 16'd0) begin
      failures++; $display("FAIL reset_gen_count got %0d expected 0", gen_count);
    end
`endif
    rst = 1'b0;
    repeat (10) tick();
    checks++;
    if (starts != 0 || busy !== 1'b0) begin
      failures++; $display("FAIL reset_idle starts=%0d busy=%b expected 0/0", starts, busy);
    end
  endtask

  task automatic test_reset_mid_compute();
    do_reset();
    tick(0, 0, 1);
    repeat (3) tick();
    checks++;
    if (busy !== 1'b1 || starts != 1) begin
      failures++; $display("FAIL mid_compute_busy busy=%b starts=%0d expected 1/1", busy, starts);
    end
    #3 rst = 1'b1;
    #1;
    checks++;
    if ({start, swap, busy} !== 3'b000) begin
      failures++; $display("FAIL async_reset_outputs got %b expected 000", {start, swap, busy});
    end
    tick();
    rst = 1'b0; starts = 0; eng_pend = 0;
    tick(0, 1, 0);
    tick(1, 0, 0);
    repeat (10) tick();
    checks++;
    if (swaps != 0 || starts != 0 || busy !== 1'b0) begin
      failures++; $display("FAIL post_reset_quiet swaps=%0d starts=%0d busy=%b expected 0/0/0", swaps, starts, busy);
    end
  endtask

  task automatic run_frames(input int spd, input int per, input int dly, input int every,
                            input int phase, input int frames);
    do_reset();
    auto_eng = 1; eng_delay = dly;
    vper = per; vs_ctr = per - 1; vs_idx = 0; swap_every = every; swap_phase = phase;
    speed = spd[3:0]; run = 1'b1; auto_vs = 1;
    repeat (frames * per + 5) tick();
    auto_vs = 0; run = 1'b0;
  endtask

  task automatic test_speed0();
    run_frames(0, 1000, 50, 1, 0, 5);
    checks++;
    if (swaps != 5 || starts != 6) begin
      failures++; $display("FAIL speed0_counts swaps=%0d starts=%0d expected 5/6", swaps, starts);
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++; $display("FAIL speed0_missing_swaps left=%0d expected 0", exp_q.size());
    end
  endtask

  task automatic test_speed2();
    run_frames(2, 200, 50, 3, 2, 9);
    checks++;
    if (swaps != 3 || starts != 3) begin
      failures++; $display("FAIL speed2_counts swaps=%0d starts=%0d expected 3/3", swaps, starts);
    end
`ifdef GEN_COUNT_EN
    checks++;
    if (gen_count !== 16'd3) begin
      failures++; $display("FAIL speed2_gen_count got %0d expected 3", gen_count);
    end
`endif
    checks++;
    if (exp_q.size() != 0) begin
      failures++; $display("FAIL speed2_missing_swaps left=%0d expected 0", exp_q.size());
    end
  endtask

  task automatic test_speed_max();
    run_frames(15, 100, 20, 16, 15, 32);
    checks++;
    if (swaps != 2 || starts != 2 || exp_q.size() != 0) begin
      failures++; $display("FAIL speedmax_counts swaps=%0d starts=%0d left=%0d expected 2/2/0", swaps, starts, exp_q.size());
    end
  endtask

  task automatic test_single_step();
    int n;
    do_reset();
    auto_eng = 1; eng_delay = 10;
    tick();
    tick(0, 0, 1); n = cyc;
    repeat (3) tick();
    checks++;
    if (starts != 1 || last_start != n + 2) begin
      failures++; $display("FAIL step_start starts=%0d at %0d expected 1 at %0d", starts, last_start, n + 2);
    end
    tick(0, 0, 1);
    repeat (15) tick();
    tick(1); exp_q.push_back(cyc + 1);
    repeat (4) tick();
    checks++;
    if (starts != 2 || last_start != last_swap + 2) begin
      failures++; $display("FAIL step_second_start starts=%0d at %0d expected 2 at %0d", starts, last_start, last_swap + 2);
    end
    repeat (15) tick();
    tick(1); exp_q.push_back(cyc + 1);
    repeat (20) tick();
    tick(1);
    repeat (5) tick();
    checks++;
    if (starts != 2 || swaps != 2 || busy !== 1'b0 || exp_q.size() != 0) begin
      failures++; $display("FAIL step_final starts=%0d swaps=%0d busy=%b left=%0d expected 2/2/0/0", starts, swaps, busy, exp_q.size());
    end
  endtask

  task automatic test_done_with_vsync();
    do_reset();
    tick(0, 0, 1);
    repeat (8) tick();
    tick(1, 1, 0); exp_q.push_back(cyc + 1);
    repeat (3) tick();
    checks++;
    if (swaps != 1 || busy !== 1'b0 || exp_q.size() != 0) begin
      failures++; $display("FAIL coincident_swap swaps=%0d busy=%b left=%0d expected 1/0/0", swaps, busy, exp_q.size());
    end
  endtask

  task automatic test_spurious();
    do_reset();
    speed = 4'd15;
    tick(0, 1, 0);
    repeat (5) tick();
    run = 1'b1;
    tick(0, 0, 1);
    repeat (3) tick();
    run = 1'b0;
    repeat (5) tick();
    checks++;
    if (starts != 0 || busy !== 1'b0) begin
      failures++; $display("FAIL spurious_idle starts=%0d busy=%b expected 0/0", starts, busy);
    end
    auto_eng = 1; eng_delay = 5;
    tick(0, 0, 1);
    repeat (10) tick();
    tick(0, 1, 0);
    repeat (3) tick();
    tick(1); exp_q.push_back(cyc + 1);
    repeat (3) tick();
    tick(1);
    repeat (5) tick();
    checks++;
    if (starts != 1 || swaps != 1 || busy !== 1'b0 || exp_q.size() != 0) begin
      failures++; $display("FAIL spurious_wait_frame starts=%0d swaps=%0d busy=%b left=%0d expected 1/1/0/0", starts, swaps, busy, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid_compute();
    test_speed0();
    test_speed2();
    test_speed_max();
    test_single_step();
    test_done_with_vsync();
    test_spurious();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
